// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
// proc_pkg : opcodes, FSM states, ALU selects and instruction field slices
// Revision  : 1.0
// ============================================================================
package proc_pkg;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'h0,
    OP_STORE = 4'h1,
    OP_LOAD  = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_HALT  = 4'h5
  } opcode_e;

  // ST_INIT must stay at zero so State_Out reads 0 straight out of reset.
  typedef enum logic [3:0] {
    ST_INIT    = 4'd0,
    ST_FETCH   = 4'd1,
    ST_FETCH_W = 4'd2,
    ST_DECODE  = 4'd3,
    ST_LOAD_A  = 4'd4,
    ST_LOAD_B  = 4'd5,
    ST_STORE   = 4'd6,
    ST_ADD     = 4'd7,
    ST_SUB     = 4'd8,
    ST_NOOP    = 4'd9,
    ST_HALT    = 4'd10
  } state_e;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

  localparam int OPC_MSB     = 15;
  localparam int OPC_LSB     = 12;
  localparam int RA_MSB      = 11;
  localparam int RA_LSB      = 8;
  localparam int RB_MSB      = 7;
  localparam int RB_LSB      = 4;
  localparam int RD_MSB      = 3;
  localparam int RD_LSB      = 0;
  localparam int ST_ADDR_MSB = 7;
  localparam int ST_ADDR_LSB = 0;
  localparam int LD_ADDR_MSB = 11;
  localparam int LD_ADDR_LSB = 4;

  // Unused opcode values collapse to NOOP.
  function automatic opcode_e decode_op(input logic [15:0] ir);
    opcode_e op;
    case (ir[OPC_MSB:OPC_LSB])
      4'h1:    op = OP_STORE;
      4'h2:    op = OP_LOAD;
      4'h3:    op = OP_ADD;
      4'h4:    op = OP_SUB;
      4'h5:    op = OP_HALT;
      default: op = OP_NOOP;
    endcase
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_counter.sv
`default_nettype none
// ============================================================================
// pc_counter : program counter with synchronous clear and increment enable
// Revision   : 1.0
// ============================================================================
module pc_counter #(
  parameter int PC_W = 7
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  // Wrap from all-ones to zero falls out of the natural overflow.
  always_comb begin
    pc_d = pc_q;
    if (inc) begin
      pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// control_unit : fetch/decode/execute sequencer driving datapath controls
// Revision     : 1.0
// ============================================================================
module control_unit
  import proc_pkg::*;
#(
  parameter int PC_W = 7
) (
  input  logic            clk,
  input  logic            reset,
  output logic [PC_W-1:0] IM_Addr,
  input  logic [15:0]     IM_Data,
  output logic [7:0]      D_Addr,
  output logic            D_WriteEn,
  output logic            MuxS,
  output logic [3:0]      RegF_W_addr,
  output logic            RegF_W_en,
  output logic [3:0]      RegF_Ra_addr,
  output logic [3:0]      RegF_Rb_addr,
  output logic [2:0]      ALU_S,
  output logic [PC_W-1:0] PC_Out,
  output logic [15:0]     IR_Out,
  output logic [3:0]      State_Out
);

  state_e          state_q;
  state_e          state_d;
  logic [15:0]     ir_q;
  logic [15:0]     ir_d;
  logic [PC_W-1:0] pc;
  logic            pc_inc;

  pc_counter #(
    .PC_W (PC_W)
  ) u_pc_counter (
    .clk (clk),
    .clr (reset),
    .inc (pc_inc),
    .pc  (pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // ROM data is valid in FETCH_W, so IR capture and PC advance share its exit edge.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_inc  = 1'b0;
    case (state_q)
      ST_INIT:    state_d = ST_FETCH;
      ST_FETCH:   state_d = ST_FETCH_W;
      ST_FETCH_W: begin
        state_d = ST_DECODE;
        ir_d    = IM_Data;
        pc_inc  = 1'b1;
      end
      ST_DECODE: begin
        case (decode_op(ir_q))
          OP_LOAD:  state_d = ST_LOAD_A;
          OP_STORE: state_d = ST_STORE;
          OP_ADD:   state_d = ST_ADD;
          OP_SUB:   state_d = ST_SUB;
          OP_HALT:  state_d = ST_HALT;
          default:  state_d = ST_NOOP;
        endcase
      end
      ST_LOAD_A:  state_d = ST_LOAD_B;
      ST_LOAD_B,
      ST_STORE,
      ST_ADD,
      ST_SUB,
      ST_NOOP:    state_d = ST_FETCH;
      ST_HALT:    state_d = ST_HALT;
      default:    state_d = ST_INIT;
    endcase
  end

  always_comb begin
    IM_Addr      = '0;
    D_Addr       = '0;
    D_WriteEn    = 1'b0;
    MuxS         = 1'b0;
    RegF_W_addr  = '0;
    RegF_W_en    = 1'b0;
    RegF_Ra_addr = '0;
    RegF_Rb_addr = '0;
    ALU_S        = ALU_PASS;
    case (state_q)
      ST_FETCH,
      ST_FETCH_W: IM_Addr = pc;
      // Address and destination are held across both LOAD states so the
      // memory read data is settled by the LOAD_B write edge.
      ST_LOAD_A,
      ST_LOAD_B: begin
        D_Addr      = ir_q[LD_ADDR_MSB:LD_ADDR_LSB];
        MuxS        = 1'b1;
        RegF_W_addr = ir_q[RD_MSB:RD_LSB];
        RegF_W_en   = (state_q == ST_LOAD_B);
      end
      ST_STORE: begin
        RegF_Ra_addr = ir_q[RA_MSB:RA_LSB];
        D_Addr       = ir_q[ST_ADDR_MSB:ST_ADDR_LSB];
        D_WriteEn    = 1'b1;
      end
      ST_ADD,
      ST_SUB: begin
        RegF_Ra_addr = ir_q[RA_MSB:RA_LSB];
        RegF_Rb_addr = ir_q[RB_MSB:RB_LSB];
        ALU_S        = (state_q == ST_ADD) ? ALU_ADD : ALU_SUB;
        RegF_W_addr  = ir_q[RD_MSB:RD_LSB];
        RegF_W_en    = 1'b1;
      end
      default: ;
    endcase
  end

  assign PC_Out    = pc;
  assign IR_Out    = ir_q;
  assign State_Out = state_q;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// tb_control_unit : self-checking bench with an instruction-level reference model
// Revision        : 1.0
// ============================================================================
module tb_control_unit;

  localparam int PC_W = 7;

  typedef struct packed {
    logic [6:0] im;
    logic [7:0] daddr;
    logic       dwe;
    logic       muxs;
    logic [3:0] wa;
    logic       wen;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [2:0] alu;
  } ctrl_t;

  logic            clk;
  logic            reset;
  logic [PC_W-1:0] IM_Addr;
  logic [15:0]     IM_Data;
  logic [7:0]      D_Addr;
  logic            D_WriteEn;
  logic            MuxS;
  logic [3:0]      RegF_W_addr;
  logic            RegF_W_en;
  logic [3:0]      RegF_Ra_addr;
  logic [3:0]      RegF_Rb_addr;
  logic [2:0]      ALU_S;
  logic [PC_W-1:0] PC_Out;
  logic [15:0]     IR_Out;
  logic [3:0]      State_Out;

  logic [15:0] rom [0:127];
  logic [6:0]  m_pc;
  int          n_checks;
  int          n_fail;

  control_unit #(.PC_W(PC_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .IM_Addr      (IM_Addr),
    .IM_Data      (IM_Data),
    .D_Addr       (D_Addr),
    .D_WriteEn    (D_WriteEn),
    .MuxS         (MuxS),
    .RegF_W_addr  (RegF_W_addr),
    .RegF_W_en    (RegF_W_en),
    .RegF_Ra_addr (RegF_Ra_addr),
    .RegF_Rb_addr (RegF_Rb_addr),
    .ALU_S        (ALU_S),
    .PC_Out       (PC_Out),
    .IR_Out       (IR_Out),
    .State_Out    (State_Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered instruction ROM: one cycle from address to data.
  always @(posedge clk) IM_Data <= rom[IM_Addr];

  function automatic ctrl_t obs();
    ctrl_t o;
    o = {IM_Addr, D_Addr, D_WriteEn, MuxS, RegF_W_addr, RegF_W_en,
         RegF_Ra_addr, RegF_Rb_addr, ALU_S};
    return o;
  endfunction

  // Expected controls in cycle k of an instruction (k=0 is FETCH entry).
  function automatic ctrl_t exp_cycle(input logic [15:0] instr, input logic [6:0] pc, input int k);
    ctrl_t       e;
    logic [3:0]  op;
    e  = '0;
    op = instr[15:12];
    if (k < 2) begin
      e.im = pc;
    end else if (k >= 3) begin
      case (op)
        4'h1: begin
          e.ra = instr[11:8]; e.daddr = instr[7:0]; e.dwe = 1'b1;
        end
        4'h2: begin
          e.daddr = instr[11:4]; e.muxs = 1'b1; e.wa = instr[3:0]; e.wen = (k == 4);
        end
        4'h3, 4'h4: begin
          e.ra = instr[11:8]; e.rb = instr[7:4]; e.wa = instr[3:0]; e.wen = 1'b1;
          e.alu = (op == 4'h3) ? 3'd1 : 3'd2;
        end
        default: ;
      endcase
    end
    return e;
  endfunction

  function automatic int ncyc(input logic [15:0] instr);
    logic [3:0] op;
    op = instr[15:12];
    return (op == 4'h2) ? 5 : 4;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs() !== '0) begin
      n_fail++; $display("FAIL reset_ctrl: got %h want 0", obs());
    end
    n_checks++;
    if (PC_Out !== '0 || IR_Out !== '0 || State_Out !== '0) begin
      n_fail++; $display("FAIL reset_debug: got pc=%h ir=%h st=%h want 0", PC_Out, IR_Out, State_Out);
    end
    reset = 1'b0;
    step();
    m_pc = '0;
    n_checks++;
    if (obs() !== exp_cycle(16'h0, 7'd0, 0)) begin
      n_fail++; $display("FAIL first_fetch: got %h want %h", obs(), exp_cycle(16'h0, 7'd0, 0));
    end
  endtask

  task automatic test_instr(input string name);
    logic [15:0] instr;
    instr = rom[m_pc];
    for (int k = 0; k < ncyc(instr); k++) begin
      n_checks++;
      if (obs() !== exp_cycle(instr, m_pc, k)) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h want %h", name, k, obs(), exp_cycle(instr, m_pc, k));
      end
      if (k == 2) begin
        n_checks++;
        if (IR_Out !== instr) begin
          n_fail++; $display("FAIL %s ir: got %h want %h", name, IR_Out, instr);
        end
      end
      step();
    end
    m_pc = m_pc + 7'd1;
    n_checks++;
    if (PC_Out !== m_pc || IM_Addr !== m_pc) begin
      n_fail++; $display("FAIL %s next_pc: got pc=%0d im=%0d want %0d", name, PC_Out, IM_Addr, m_pc);
    end
  endtask

  task automatic test_illegal_halt();
    logic [15:0] instr;
    test_instr("illegal");
    instr = rom[m_pc];
    for (int k = 0; k < 28; k++) begin
      n_checks++;
      if (obs() !== exp_cycle(instr, m_pc, k)) begin
        n_fail++; $display("FAIL halt cycle %0d: got %h want %h", k, obs(), exp_cycle(instr, m_pc, k));
      end
      if (k >= 3) begin
        n_checks++;
        if (PC_Out !== 7'd5) begin
          n_fail++; $display("FAIL halt_pc cycle %0d: got %0d want 5", k, PC_Out);
        end
      end
      step();
    end
    reset = 1'b1;
    step();
    n_checks++;
    if (obs() !== '0 || PC_Out !== '0 || State_Out !== '0) begin
      n_fail++; $display("FAIL halt_reset: got ctrl=%h pc=%0d st=%0d want 0", obs(), PC_Out, State_Out);
    end
    reset = 1'b0;
    step();
    m_pc = '0;
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [3:0]  op;
    logic [15:0] instr;
    for (int i = 0; i < 128; i++) begin
      r  = $urandom;
      op = 4'($urandom_range(0, 14));
      if (op >= 4'h5) op = op + 4'h1;
      rom[i] = {op, r[11:0]};
    end
    rom[127] = 16'h0000;
    test_reset();
    for (int n = 0; n < 140; n++) begin
      instr = rom[m_pc];
      for (int k = 0; k < ncyc(instr); k++) begin
        n_checks++;
        if (obs() !== exp_cycle(instr, m_pc, k)) begin
          n_fail++;
          $display("FAIL random pc=%0d instr=%h cycle %0d: got %h want %h",
                   m_pc, instr, k, obs(), exp_cycle(instr, m_pc, k));
        end
        n_checks++;
        if (D_WriteEn === 1'b1 && RegF_W_en === 1'b1) begin
          n_fail++; $display("FAIL random_both_we: got dwe=1 wen=1 want at most one");
        end
        step();
      end
      m_pc = m_pc + 7'd1;
    end
  endtask

  task automatic test_pc_wrap();
    for (int n = 0; n < 128 && m_pc != 7'd127; n++) begin
      repeat (ncyc(rom[m_pc])) step();
      m_pc = m_pc + 7'd1;
    end
    n_checks++;
    if (PC_Out !== 7'd127 || IM_Addr !== 7'd127) begin
      n_fail++; $display("FAIL wrap_pre: got pc=%0d im=%0d want 127", PC_Out, IM_Addr);
    end
    repeat (4) step();
    n_checks++;
    if (PC_Out !== 7'd0 || IM_Addr !== 7'd0) begin
      n_fail++; $display("FAIL wrap_post: got pc=%0d im=%0d want 0", PC_Out, IM_Addr);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] r;
    logic [15:0] instr;
    r      = $urandom;
    instr  = {4'h2, r[11:0]};
    rom[0] = instr;
    test_reset();
    repeat (3) step();
    n_checks++;
    if (obs() !== exp_cycle(instr, 7'd0, 3)) begin
      n_fail++; $display("FAIL midload_loada: got %h want %h", obs(), exp_cycle(instr, 7'd0, 3));
    end
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      n_checks++;
      if (State_Out !== '0 || IR_Out !== '0 || PC_Out !== '0 || obs() !== '0) begin
        n_fail++;
        $display("FAIL midload_reset %0d: got st=%0d ir=%h pc=%0d ctrl=%h want 0",
                 c, State_Out, IR_Out, PC_Out, obs());
      end
    end
    reset = 1'b0;
    step();
    n_checks++;
    if (obs() !== exp_cycle(instr, 7'd0, 0)) begin
      n_fail++; $display("FAIL midload_refetch: got %h want %h", obs(), exp_cycle(instr, 7'd0, 0));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    m_pc     = '0;
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    rom[0] = 16'h20B1;
    rom[1] = 16'h3125;
    rom[2] = 16'h10CD;
    rom[3] = 16'hF000;
    rom[4] = 16'h5000;

    test_reset();
    test_instr("load");
    test_instr("add");
    test_instr("store");
    test_illegal_halt();
    test_random();
    test_pc_wrap();
    test_reset_mid_load();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/control_unit.md
# control_unit

Instruction-sequencing state machine that drives the processor datapath's control inputs. Holds the program counter and instruction register, fetches 16-bit instructions from a registered instruction ROM, and decodes each into the datapath's control signals: data-memory address and write enable, write-back mux select, register-file addresses and enable, and ALU select. It is the initiator side of the datapath control interface. Top level is processor = control_unit + instruction ROM + datapath.

## Interface
- PC_W, 7: program counter / instruction ROM address width
- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- IM_Addr  out  PC_W  instruction ROM address, the current PC
- IM_Data  in  16  instruction ROM output, one-cycle registered latency
- D_Addr  out  8  data-memory address
- D_WriteEn  out  1  data-memory write enable
- MuxS  out  1  write-back select: 1 = memory read data, 0 = ALU output
- RegF_W_addr  out  4  register-file write address
- RegF_W_en  out  1  register-file write enable
- RegF_Ra_addr  out  4  register-file read port A address, feeds ALU A and memory write data
- RegF_Rb_addr  out  4  register-file read port B address
- ALU_S  out  3  ALU function: 0 = pass A, 1 = A+B, 2 = A−B
- PC_Out  out  PC_W  debug copy of the PC
- IR_Out  out  16  debug copy of the IR
- State_Out  out  4  debug encoding of the current state

## Operation
- Instruction fields are decoded from IR[15:12].
  - 0000 NOOP
  - 0001 STORE: Ra = IR[11:8], addr = IR[7:0]
  - 0010 LOAD: addr = IR[11:4], Rd = IR[3:0]
  - 0011 ADD: Ra = IR[11:8], Rb = IR[7:4], Rd = IR[3:0]
  - 0100 SUB: same fields as ADD
  - 0101 HALT
  - 0110–1111 are illegal and execute as NOOP.
- States: INIT, FETCH, FETCH_W, DECODE, LOAD_A, LOAD_B, STORE, ADD, SUB, NOOP, HALT.
- Transitions:
  - INIT → FETCH → FETCH_W → DECODE
  - DECODE → state selected by opcode
  - LOAD_A → LOAD_B → FETCH
  - STORE, ADD, SUB, NOOP → FETCH
  - HALT → HALT until reset
- Moore outputs. Any signal not listed for a state is 0.
  - LOAD_A: D_Addr = addr, MuxS = 1, RegF_W_addr = Rd, RegF_W_en = 0. This cycle covers the data-memory read latency.
  - LOAD_B: same as LOAD_A, but RegF_W_en = 1.
  - STORE: RegF_Ra_addr = Ra, D_Addr = addr, D_WriteEn = 1.
  - ADD: RegF_Ra_addr = Ra, RegF_Rb_addr = Rb, ALU_S = 1, MuxS = 0, RegF_W_addr = Rd, RegF_W_en = 1.
  - SUB: as ADD, with ALU_S = 2.
- At most one of D_WriteEn and RegF_W_en is asserted in any cycle.
- PC: increments by 1 at the end of FETCH_W. It wraps from 2^PC_W−1 to 0, with no flag.
- IR: loads IM_Data at the end of FETCH_W and is otherwise held.

## Timing
- Reset:
  - Next posedge with reset high gives state = INIT, PC = 0, IR = 0.
  - Every output is 0 in INIT, including IM_Addr = 0.
  - Reset overrides every state, including mid-LOAD and HALT.
  - No write enable is asserted in the cycle after reset.
- IM_Addr = PC during FETCH and FETCH_W. The ROM registers the address at the end of FETCH, and data is valid during FETCH_W.
- Cycles per instruction, from FETCH entry to the next FETCH entry:
  - LOAD: 5
  - STORE, ADD, SUB, NOOP: 4
- D_Addr and RegF_W_addr are identical across LOAD_A and LOAD_B, so memory data is stable at the LOAD_B write edge.
- Register-file and memory writes occur at the posedge ending the enabling state.

## Structure
- Package proc_pkg holds:
  - the opcode enum (4-bit)
  - the state enum (4-bit, exported as State_Out)
  - ALU_S constants ALU_PASS, ALU_ADD, ALU_SUB
  - field-slice localparams for the instruction format
- Sub-module pc_counter: PC_W-bit register with synchronous clear and increment enable, wrap by natural overflow.
- The FSM and the output decode stay in control_unit.

## Test plan
- Reset high for 2 cycles, then released: all outputs are 0, and the first FETCH drives IM_Addr = 0 one cycle after release.
- ROM[0] = 0x20B1 (LOAD addr 0x0B → R1): LOAD_A and LOAD_B drive D_Addr = 11, MuxS = 1, RegF_W_addr = 1. RegF_W_en is 0 in LOAD_A and 1 in LOAD_B. Total is 5 cycles, and PC = 1 afterwards.
- ROM[1] = 0x3125 (ADD R1 + R2 → R5): RegF_Ra_addr = 1, RegF_Rb_addr = 2, ALU_S = 1, MuxS = 0, RegF_W_addr = 5, RegF_W_en = 1 for exactly one cycle.
- ROM[2] = 0x10CD (STORE R0 → mem 205): D_Addr = 205, RegF_Ra_addr = 0, D_WriteEn = 1 for exactly one cycle, RegF_W_en = 0.
- ROM[3] = 0xF000 (illegal), then ROM[4] = 0x5000 (HALT): the illegal word passes as NOOP with no enables. After HALT, outputs stay 0 and PC stays at 5 for 20+ cycles. Reset then returns the unit to INIT with PC = 0.
- PC at 127 with ROM[127] = NOOP (PC_W = 7): the next fetch address is 0.
- Reset asserted during LOAD_A: the next state is INIT, RegF_W_en is never asserted, and IR = 0.
